ser_link_sched: RTL and testbench



---
 rtl/ser_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/ser_link_sched.sv | 141 ++++++++++++++
 tb/tb_ser_link_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_sched_pkg.sv
// Shared types and defaults for the serializer slot scheduler.
package ser_sched_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_IDLE,
    ST_HDR,
    ST_PAY
  } state_t;

  localparam logic [7:0] IDLE_BYTE_DEFAULT  = 8'hBC;
  localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hA;

  // Header byte: fixed tag in the upper nibble, requester id in the lower.
  function automatic logic [7:0] build_header(input logic [3:0] tag,
                                              input logic [3:0] id);
    return {tag, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [3:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any_req
);

  // Two passes: first requesters above ptr, then wrap to those at or below it
  always_comb begin : arb_search
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (4'(j) > ptr)) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (4'(j) <= ptr)) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ser_link_sched.sv
// Slot scheduler feeding one 8-in/1-out serializer: idle, header or payload per slot.
module ser_link_sched
  import ser_sched_pkg::*;
#(
  parameter int          NUM_REQ    = 4,
  parameter int          SLOT_LEN   = 8,
  parameter logic [7:0]  IDLE_BYTE  = IDLE_BYTE_DEFAULT,
  parameter logic [3:0]  HEADER_TAG = HEADER_TAG_DEFAULT
) (
  input  logic                 clock_160,
  input  logic                 reset,
  input  logic                 link_enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           ser_data,
  output logic                 ser_enable,
  output logic                 ser_load,
  output logic [3:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          frames_sent
);

  localparam int              CNT_W     = $clog2(SLOT_LEN);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);
  localparam logic [3:0]      PTR_INIT  = 4'(NUM_REQ - 1);

  logic [CNT_W-1:0]   slot_cnt;
  logic               boundary;
  state_t             state, state_n;
  logic [3:0]         ptr, ptr_n;
  logic [7:0]         data_n;
  logic               en_n;
  logic [3:0]         gid_n;
  logic               count_en;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               any_req;
  logic [3:0]         arb_id;
  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               hdr_xfer;

  assign boundary = (slot_cnt == SLOT_LAST);
  assign busy     = (state == ST_HDR) || (state == ST_PAY);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .any_req (any_req)
  );

  // Free-running slot counter; slot boundaries fall on its last value
  always_ff @(posedge clock_160) begin
    if (reset)         slot_cnt <= '0;
    else if (boundary) slot_cnt <= '0;
    else               slot_cnt <= slot_cnt + 1'b1;
  end

  // Encode the arbiter's one-hot winner and mux out the current grantee's lines
  always_comb begin
    arb_id    = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_gnt[j]) arb_id = 4'(j);
      if (4'(j) == grant_id) begin
        sel_valid = req_valid[j];
        sel_data  = req_data[8*j +: 8];
      end
    end
  end

  // Payload handshake happens only on the boundary cycle that ends a header slot
  assign hdr_xfer = !reset && boundary && (state == ST_HDR) && sel_valid;

  // One-hot ready pulse toward the granted requester
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = hdr_xfer && (4'(j) == grant_id);
    end
  end

  // Decide what the next slot carries; nothing changes away from a boundary
  always_comb begin
    state_n  = state;
    data_n   = ser_data;
    en_n     = ser_enable;
    gid_n    = grant_id;
    ptr_n    = ptr;
    count_en = 1'b0;
    if (boundary) begin
      if (state == ST_HDR) begin
        // A started frame always gets its payload slot, even if the link drops
        state_n  = ST_PAY;
        en_n     = 1'b1;
        data_n   = sel_valid ? sel_data : IDLE_BYTE;
        count_en = sel_valid;
      end else if (!link_enable) begin
        state_n = ST_OFF;
        en_n    = 1'b0;
        data_n  = 8'h00;
      end else if (any_req) begin
        state_n = ST_HDR;
        en_n    = 1'b1;
        gid_n   = arb_id;
        ptr_n   = arb_id;
        data_n  = build_header(HEADER_TAG, arb_id);
      end else begin
        state_n = ST_IDLE;
        en_n    = 1'b1;
        data_n  = IDLE_BYTE;
      end
    end
  end

  // Register the slot decision; the load strobe marks the first cycle of an active slot
  always_ff @(posedge clock_160) begin
    if (reset) begin
      state       <= ST_OFF;
      ser_data    <= 8'h00;
      ser_enable  <= 1'b0;
      ser_load    <= 1'b0;
      grant_id    <= '0;
      ptr         <= PTR_INIT;
      frames_sent <= '0;
    end else begin
      state      <= state_n;
      ser_data   <= data_n;
      ser_enable <= en_n;
      ser_load   <= boundary && (state_n != ST_OFF);
      grant_id   <= gid_n;
      ptr        <= ptr_n;
      if (count_en) frames_sent <= frames_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_ser_link_sched.sv
// Scoreboard bench for ser_link_sched: expected slot bytes and ready pulses are queued
// by the stimulus and checked by an independent monitor.
module tb_ser_link_sched;

  localparam int NUM_REQ  = 4;
  localparam int SLOT_LEN = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        link_enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  ser_data;
  logic        ser_enable;
  logic        ser_load;
  logic [3:0]  grant_id;
  logic        busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int tb_cnt = 0;

  logic [7:0] exp_q[$];
  logic [3:0] rdy_q[$];

  always #5 clk = ~clk;

  ser_link_sched #(
    .NUM_REQ  (NUM_REQ),
    .SLOT_LEN (SLOT_LEN)
  ) dut (
    .clock_160   (clk),
    .reset       (reset),
    .link_enable (link_enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .ser_data    (ser_data),
    .ser_enable  (ser_enable),
    .ser_load    (ser_load),
    .grant_id    (grant_id),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  // Reference slot position, kept independently of the DUT
  always @(posedge clk) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == SLOT_LEN - 1) ? 0 : tb_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic goto_slot();
    do begin
      @(posedge clk);
      #1;
    end while (tb_cnt != 0);
  endtask

  task automatic slot(input logic [7:0] nxt);
    exp_q.push_back(nxt);
    goto_slot();
  endtask

  task automatic set_req(input int id, input logic [7:0] d);
    req_data[8*id +: 8] = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ser_data"},    32'(ser_data),    32'h00);
    chk({tag, "_ser_enable"},  32'(ser_enable),  32'h0);
    chk({tag, "_ser_load"},    32'(ser_load),    32'h0);
    chk({tag, "_req_ready"},   32'(req_ready),   32'h0);
    chk({tag, "_grant_id"},    32'(grant_id),    32'h0);
    chk({tag, "_busy"},        32'(busy),        32'h0);
    chk({tag, "_frames_sent"}, 32'(frames_sent), 32'h0);
  endtask

  // Monitor: every load and every ready pulse must match the next queued expectation
  always @(negedge clk) begin
    logic [7:0] e;
    logic [3:0] r;
    if (ser_load) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected got data=%h cnt=%0d want no load", ser_data, tb_cnt);
      end else begin
        e = exp_q.pop_front();
        if (ser_data !== e || ser_enable !== 1'b1 || tb_cnt != 0) begin
          errors++;
          $display("FAIL slot_byte got data=%h en=%b cnt=%0d want data=%h en=1 cnt=0",
                   ser_data, ser_enable, tb_cnt, e);
        end
      end
    end
    if (req_ready !== 4'b0000) begin
      checks++;
      if (rdy_q.size() == 0) begin
        errors++;
        $display("FAIL ready_unexpected got %b want 0000", req_ready);
      end else begin
        r = rdy_q.pop_front();
        if (req_ready !== r || tb_cnt != SLOT_LEN - 1) begin
          errors++;
          $display("FAIL ready_pulse got %b cnt=%0d want %b cnt=%0d",
                   req_ready, tb_cnt, r, SLOT_LEN - 1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    link_enable = 1'b0;
    req_valid   = 4'b0000;
    req_data    = 32'h0;

    // 1: reset, then link off for three slots
    repeat (4) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      goto_slot();
      chk("off_enable", 32'(ser_enable), 32'h0);
      chk("off_data",   32'(ser_data),   32'h00);
    end

    // 2: link on, nothing to send
    link_enable = 1'b1;
    slot(8'hBC);
    slot(8'hBC);
    slot(8'hBC);

    // 3: single frame from requester 2
    req_valid = 4'b0100;
    set_req(2, 8'hBB);
    rdy_q.push_back(4'b0100);
    slot(8'hA2);
    chk("hdr_busy",  32'(busy),     32'h1);
    chk("hdr_grant", 32'(grant_id), 32'h2);
    slot(8'hBB);
    req_valid = 4'b0000;
    chk("frames_1", 32'(frames_sent), 32'd1);
    slot(8'hBC);

    // 4: all requesters valid; pointer sits at 2, so service order is 3,0,1,2
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h10 + i));
    for (int k = 0; k < NUM_REQ; k++) begin
      int id;
      id = (3 + k) % NUM_REQ;
      rdy_q.push_back(4'(1 << id));
      slot(8'(8'hA0 + id));
      slot(8'(8'h10 + id));
    end
    req_valid = 4'b0000;
    chk("frames_5", 32'(frames_sent), 32'd5);
    slot(8'hBC);

    // 5a: requester 1 drops valid during its header slot
    req_valid = 4'b0010;
    set_req(1, 8'h55);
    slot(8'hA1);
    req_valid = 4'b0000;
    slot(8'hBC);
    chk("frames_drop", 32'(frames_sent), 32'd5);

    // 5b: link drops during a header slot; payload still goes, then off
    req_valid = 4'b0001;
    set_req(0, 8'h77);
    rdy_q.push_back(4'b0001);
    slot(8'hA0);
    link_enable = 1'b0;
    slot(8'h77);
    req_valid = 4'b0000;
    chk("frames_6", 32'(frames_sent), 32'd6);
    goto_slot();
    chk("linkoff_enable", 32'(ser_enable), 32'h0);
    chk("linkoff_data",   32'(ser_data),   32'h00);
    chk("linkoff_busy",   32'(busy),       32'h0);

    // 6a: reset in the middle of a payload slot
    link_enable = 1'b1;
    req_valid   = 4'b1000;
    set_req(3, 8'h3C);
    rdy_q.push_back(4'b1000);
    slot(8'hA3);
    slot(8'h3C);
    req_valid = 4'b0000;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pay_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    reset = 1'b0;

    // After reset priority restarts at requester 0, so 1 beats 3
    req_valid = 4'b1010;
    set_req(1, 8'h11);
    rdy_q.push_back(4'b0010);
    slot(8'hA1);
    slot(8'h11);
    req_valid = 4'b0000;
    chk("frames_post_rst", 32'(frames_sent), 32'd1);
    slot(8'hBC);

    // 6b: counter wrap from 16'hFFFF
    force dut.frames_sent = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frames_sent;
    chk("frames_preload", 32'(frames_sent), 32'hFFFF);
    req_valid = 4'b0100;
    set_req(2, 8'h22);
    rdy_q.push_back(4'b0100);
    slot(8'hA2);
    slot(8'h22);
    req_valid   = 4'b0000;
    link_enable = 1'b0;
    chk("frames_wrap", 32'(frames_sent), 32'h0);
    goto_slot();
    repeat (3) @(posedge clk);
    #1;

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("rdy_q_drained", 32'(rdy_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
